// File: rtl/crp16_mul_seq.sv
// crp16_mul_seq
// Multi-cycle unsigned 16x16 multiplier for the CRP16 execute stage.
// The block has no adder of its own. It borrows the ALU adder through the
// alu_* port set and runs one shift-add iteration per clock. Each product
// takes 17 cycles from the accepted start to the done pulse.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   request; only sampled while idle
//   x, y        in   16-bit multiplicand / multiplier, captured with start
//   alu_out     in   16-bit ALU sum for the current alu_x/alu_y
//   alu_c       in   ALU carry-out for the current add
//   alu_x/alu_y out  ALU operands (zero unless an iteration is running)
//   alu_select  out  ALU operation select, tied to add (4'b0000)
//   busy        out  high while running or reporting done
//   done        out  one-cycle pulse; product/ovf are valid
//   product     out  32-bit registered product, held until the next accept
//   ovf         out  high when the product does not fit in 16 bits

module crp16_mul_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] alu_out,
  input  logic        alu_c,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [3:0]  alu_select,
  output logic        busy,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] acc_hi;
  logic [15:0] acc_lo;
  logic [15:0] mcand;
  logic [3:0]  count;

  logic [15:0] shift_hi;
  logic [15:0] shift_lo;
  logic        last_iter;

  // The 33-bit value {carry, sum, acc_lo} moves right by one bit each
  // iteration. The retired multiplier bit drops out of acc_lo. The low
  // product bit takes its place at the top of acc_lo.
  always_comb begin
    shift_hi  = {alu_c, alu_out[15:1]};
    shift_lo  = {alu_out[0], acc_lo[15:1]};
    last_iter = (count == 4'd15);
  end

  // Next-state and ALU operand decode. The operands depend only on
  // registers, so there is no combinational path from the inputs to the
  // ALU operands.
  always_comb begin
    state_next = state;
    alu_x      = 16'd0;
    alu_y      = 16'd0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        alu_x = acc_hi;
        alu_y = acc_lo[0] ? mcand : 16'd0;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath registers. product and ovf are left unchanged when a new
  // request is accepted. They are only rewritten by the final iteration
  // of that request.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_hi  <= 16'd0;
      acc_lo  <= 16'd0;
      mcand   <= 16'd0;
      count   <= 4'd0;
      product <= 32'd0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= x;
            acc_lo <= y;
            acc_hi <= 16'd0;
            count  <= 4'd0;
          end
        end
        RUN: begin
          acc_hi <= shift_hi;
          acc_lo <= shift_lo;
          count  <= count + 4'd1;
          if (last_iter) begin
            product <= {shift_hi, shift_lo};
            ovf     <= (shift_hi != 16'd0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_select = 4'b0000;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

endmodule

// File: tb/tb_crp16_mul_seq.sv
// tb_crp16_mul_seq
// Self-checking bench for crp16_mul_seq. The bench models the ALU adder
// so the multiplier has something to borrow. Expected values come from
// plain integer multiplication of the captured operands. The per-cycle
// ALU operands are checked against partial products.

module tb_crp16_mul_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] alu_out;
  logic        alu_c;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [3:0]  alu_select;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        ovf;

  int vectors;
  int miscompares;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    logic        exp_o;
    logic        hold;
    int          repulse;
  } vec_t;

  vec_t vecs[$];

  crp16_mul_seq dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .x          (x),
    .y          (y),
    .alu_out    (alu_out),
    .alu_c      (alu_c),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_select (alu_select),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .ovf        (ovf)
  );

  // Clock generator.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ALU model: combinational 16-bit adder with carry-out.
  always_comb begin
    {alu_c, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
  end

  // Step to the next cycle and settle just after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request from idle and follow it to done and then to idle.
  // hold keeps start (and x/y) asserted for a back-to-back re-accept.
  // repulse re-asserts start with x=y=7 in that RUN cycle. The multiplier
  // must ignore it.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [31:0] exp_p, input logic exp_o,
                               input logic hold, input int repulse);
    int lat;
    longint unsigned mask;
    longint unsigned part;
    x     = a;
    y     = b;
    start = 1'b1;
    nextCycle();
    lat = 1;
    if (!hold) begin
      start = 1'b0;
      x     = 16'($urandom);
      y     = 16'($urandom);
    end
    while (!done && lat < 40) begin
      checkOutput("busy_run", 32'(busy), 32'd1);
      checkOutput("alu_select_run", 32'(alu_select), 32'd0);
      if (lat <= 16) begin
        mask = (64'd1 << (lat - 1)) - 64'd1;
        part = (64'(a) * (64'(b) & mask)) >> (lat - 1);
        checkOutput("alu_x_run", 32'(alu_x), 32'(part[15:0]));
        checkOutput("alu_y_run", 32'(alu_y), b[lat-1] ? 32'(a) : 32'd0);
      end
      if (lat == repulse) begin
        start = 1'b1;
        x     = 16'd7;
        y     = 16'd7;
      end else if (!hold) begin
        start = 1'b0;
      end
      nextCycle();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd17);
    checkOutput("busy_done", 32'(busy), 32'd1);
    checkOutput("alu_x_done", 32'(alu_x), 32'd0);
    checkOutput("alu_y_done", 32'(alu_y), 32'd0);
    checkOutput("product", product, exp_p);
    checkOutput("ovf", 32'(ovf), 32'(exp_o));
    if (!hold) start = 1'b0;
    nextCycle();
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("done_idle", 32'(done), 32'd0);
    checkOutput("product_hold", product, exp_p);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] rp;
    int          seen_done;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    x           = 16'd0;
    y           = 16'd0;

    vecs.push_back('{16'd3,     16'd5,     32'h0000000F, 1'b0, 1'b0, -1});
    vecs.push_back('{16'hFFFF,  16'hFFFF,  32'hFFFE0001, 1'b1, 1'b0, -1});
    vecs.push_back('{16'h1234,  16'h0000,  32'h00000000, 1'b0, 1'b0, -1});
    vecs.push_back('{16'h0000,  16'hABCD,  32'h00000000, 1'b0, 1'b0, -1});
    vecs.push_back('{16'h0100,  16'h0100,  32'h00010000, 1'b1, 1'b0, 5});
    vecs.push_back('{16'd10,    16'd10,    32'd100,      1'b0, 1'b1, -1});
    vecs.push_back('{16'd10,    16'd10,    32'd100,      1'b0, 1'b0, -1});

    // Reset state
    repeat (3) nextCycle();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_product", product, 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    checkOutput("reset_alu_x", 32'(alu_x), 32'd0);
    checkOutput("reset_alu_y", 32'(alu_y), 32'd0);
    checkOutput("reset_alu_select", 32'(alu_select), 32'd0);
    reset = 1'b0;
    nextCycle();

    // Directed table, including the ignored re-pulse and back-to-back hold
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp_p, vecs[i].exp_o,
                    vecs[i].hold, vecs[i].repulse);
    end
    nextCycle();

    // Reset in the middle of an operation discards it
    x     = 16'd200;
    y     = 16'd300;
    start = 1'b1;
    nextCycle();
    start = 1'b0;
    repeat (7) nextCycle();
    reset = 1'b1;
    nextCycle();
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_product", product, 32'd0);
    checkOutput("midreset_ovf", 32'(ovf), 32'd0);
    reset     = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 20; c++) begin
      nextCycle();
      if (done) seen_done = 1;
    end
    checkOutput("midreset_no_done", 32'(seen_done), 32'd0);
    applyStimulus(16'd2, 16'd9, 32'd18, 1'b0, 1'b0, -1);

    // Random operands against integer multiplication
    for (int r = 0; r < 20; r++) begin
      ra = 16'($urandom);
      rb = (r % 4 == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rp = 32'(ra) * 32'(rb);
      applyStimulus(ra, rb, rp, (rp[31:16] != 16'd0), 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
